tmul_sched: RTL and testbench

// - Round-robin scheduler that shares one unipolar temporal multiplier (iA/iB/loadA/loadB/oC/stop

---
 rtl/tmul_sched.sv | 174 +++++++++++++++++
 tb/tb_tmul_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmul_sched.sv
`timescale 1ns/1ps
// tmul_sched: round-robin scheduler that shares one unipolar temporal multiplier
// between NREQ requesters. It grants one job at a time, loads the operands into the
// multiplier, counts oC ones while stop is low and returns the count tagged with the
// requester id.
// Optional feature macro: TMUL_SCHED_ZERO_SKIP_EN. When it is defined, jobs with a zero
// operand bypass the multiplier and complete with a zero result.
module tmul_sched #(
    parameter int DATAWD = 8,
    parameter int NREQ   = 4,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATAWD-1:0] req_a,
    input  logic [NREQ*DATAWD-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [IDW-1:0]         res_id,
    output logic [DATAWD-1:0]      res_data,
    output logic [DATAWD-1:0]      mul_iA,
    output logic [DATAWD-1:0]      mul_iB,
    output logic                   mul_loadA,
    output logic                   mul_loadB,
    input  logic                   mul_oC,
    input  logic                   mul_stop
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ARM  = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int unsigned NREQ_U = NREQ;
    localparam int unsigned DW_U   = DATAWD;

    logic [2:0]        state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    gnt_q, gnt_d;
    logic [DATAWD-1:0] cnt_q, cnt_d;
    logic [DATAWD-1:0] ia_q, ia_d;
    logic [DATAWD-1:0] ib_q, ib_d;

    logic                   any_vld;
    logic [IDW-1:0]         pick;
    logic [DATAWD-1:0]      pick_a, pick_b;
    int unsigned            slot;
    logic [IDW-1:0]         cand;
    logic [NREQ*DATAWD-1:0] sh_a, sh_b;
`ifdef TMUL_SCHED_ZERO_SKIP_EN
    logic                   zero_op;
`endif

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] g);
        return (g == IDW'(NREQ - 1)) ? '0 : g + IDW'(1);
    endfunction

    // Round-robin pick: first valid requester at or after ptr_q, wrapping, plus its operands.
    always_comb begin
        any_vld = 1'b0;
        pick    = '0;
        slot    = 0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            slot = 32'(ptr_q) + k;
            if (slot >= NREQ_U) slot = slot - NREQ_U;
            cand = IDW'(slot);
            if (!any_vld && req_valid[cand]) begin
                any_vld = 1'b1;
                pick    = cand;
            end
        end
        sh_a   = req_a >> (32'(pick) * DW_U);
        sh_b   = req_b >> (32'(pick) * DW_U);
        pick_a = sh_a[DATAWD-1:0];
        pick_b = sh_b[DATAWD-1:0];
    end

`ifdef TMUL_SCHED_ZERO_SKIP_EN
    assign zero_op = (pick_a == '0) || (pick_b == '0);
`endif

    // Next-state logic for the job sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ia_d    = ia_q;
        ib_d    = ib_q;
        case (state_q)
            ST_IDLE: begin
                if (any_vld) begin
                    gnt_d = pick;
`ifdef TMUL_SCHED_ZERO_SKIP_EN
                    // Zero-operand jobs never reach the multiplier, so the pointer
                    // advance and count clear that LOAD would do happen here instead.
                    if (zero_op) begin
                        ptr_d   = next_idx(pick);
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        ia_d    = pick_a;
                        ib_d    = pick_b;
                        state_d = ST_LOAD;
                    end
`else
                    ia_d    = pick_a;
                    ib_d    = pick_b;
                    state_d = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                ptr_d   = next_idx(gnt_q);
                cnt_d   = '0;
                state_d = ST_ARM;
            end
            ST_ARM: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mul_stop) state_d = ST_DONE;
                else          cnt_d   = cnt_q + DATAWD'(mul_oC);
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, round-robin pointer, grant, count and loaded-operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ia_q    <= '0;
            ib_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ia_q    <= ia_d;
            ib_q    <= ib_d;
        end
    end

    // One-hot accept pulse for the granted requester.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_LOAD) req_ready[gnt_q] = 1'b1;
`ifdef TMUL_SCHED_ZERO_SKIP_EN
        if (state_q == ST_IDLE && any_vld && zero_op) req_ready[pick] = 1'b1;
`endif
    end

    assign mul_loadA = (state_q == ST_LOAD);
    assign mul_loadB = (state_q == ST_LOAD);
    assign mul_iA    = ia_q;
    assign mul_iB    = ib_q;
    assign res_valid = (state_q == ST_DONE);
    assign res_id    = gnt_q;
    assign res_data  = cnt_q;

endmodule

// File: tb/tb_tmul_sched.sv
`timescale 1ns/1ps
// Bench for tmul_sched with a behavioural temporal multiplier (van der Corput /
// Sobol dim-1 comparison stream) and a scoreboard of expected results.
module tb_tmul_sched;

    logic        clk;
    logic        rst;
    logic        mrst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [7:0]  res_data;
    logic [7:0]  mul_iA;
    logic [7:0]  mul_iB;
    logic        mul_loadA;
    logic        mul_loadB;
    logic        mul_oC;
    logic        mul_stop;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] data;
        int         lat;
        bit         load;
    } exp_t;

    exp_t sb[$];

    tmul_sched #(.DATAWD(8), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .mul_iA    (mul_iA),
        .mul_iB    (mul_iB),
        .mul_loadA (mul_loadA),
        .mul_loadB (mul_loadB),
        .mul_oC    (mul_oC),
        .mul_stop  (mul_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Multiplier model: stop stays high for the cycle after load, then low for A cycles.
    logic [7:0] m_cnt, m_idx, m_b;
    logic       m_stop, m_first;
    always @(posedge clk or posedge mrst) begin
        if (mrst) begin
            m_cnt <= '0; m_idx <= '0; m_b <= '0; m_stop <= 1'b1; m_first <= 1'b0;
        end else if (mul_loadA) begin
            m_cnt <= mul_iA; m_idx <= '0; m_stop <= 1'b1; m_first <= 1'b1;
            if (mul_loadB) m_b <= mul_iB;
        end else if (m_first) begin
            m_first <= 1'b0;
            m_stop  <= (m_cnt == 8'd0);
        end else if (!m_stop) begin
            m_cnt <= m_cnt - 8'd1;
            m_idx <= m_idx + 8'd1;
            if (m_cnt == 8'd1) m_stop <= 1'b1;
        end
    end
    assign mul_stop = m_stop;
    assign mul_oC   = !m_stop && (rev8(m_idx) < m_b);

    function automatic logic [7:0] exp_count(input logic [7:0] a, input logic [7:0] b);
        int unsigned n = 0;
        for (int i = 0; i < int'(a); i++) if (rev8(8'(i)) < b) n++;
        return 8'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        bit zs;
`ifdef TMUL_SCHED_ZERO_SKIP_EN
        zs = (a == 8'd0) || (b == 8'd0);
`else
        zs = 1'b0;
`endif
        e.id   = 2'(id);
        e.a    = a;
        e.b    = b;
        e.data = zs ? 8'd0 : exp_count(a, b);
        e.lat  = zs ? 1 : 3 + int'(a);
        e.load = !zs;
        sb.push_back(e);
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid[id]    = 1'b1;
    endtask

    // Serve the job at the head of the scoreboard; called at a falling edge.
    task automatic serve(input logic [3:0] drop, input int hold, output logic [7:0] got);
        exp_t e;
        int n;
        int loads;
        logic ok;
        logic [1:0] id0;
        logic [7:0] d0;
        got = '0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        #1;
        n = 0;
        while (req_ready === 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_onehot", 32'(req_ready), 32'(4'b1 << e.id));
        chk("load_pulse", 32'({mul_loadA, mul_loadB}), e.load ? 32'd3 : 32'd0);
        if (e.load) begin
            chk("load_iA", 32'(mul_iA), 32'(e.a));
            chk("load_iB", 32'(mul_iB), 32'(e.b));
        end
        @(posedge clk);
        #1 req_valid = req_valid & ~drop;
        n = 0;
        loads = 0;
        do begin
            @(negedge clk);
            n++;
            if (mul_loadA === 1'b1 || mul_loadB === 1'b1) loads++;
        end while (res_valid !== 1'b1 && n < 400);
        chk("latency", 32'(n), 32'(e.lat));
        chk("stray_load", 32'(loads), 32'd0);
        chk("res_id", 32'(res_id), 32'(e.id));
        chk("res_data", 32'(res_data), 32'(e.data));
        got = res_data;
        id0 = res_id;
        d0  = res_data;
        ok  = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (res_valid !== 1'b1 || res_id !== id0 || res_data !== d0 ||
                req_ready !== 4'b0 || mul_loadA !== 1'b0 || mul_loadB !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        if (hold > 0) chk("hold_stable", 32'(ok), 32'd1);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_handshake", 32'(res_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        int n;
        rst = 1'b1; mrst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id",    32'(res_id),    32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_mul_iAB",   32'({mul_iA, mul_iB}), 32'd0);
        chk("rst_mul_load",  32'({mul_loadA, mul_loadB}), 32'd0);
        rst = 1'b0; mrst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'({res_valid, req_ready}), 32'd0);

        // Single long job on requester 2.
        push(2, 8'd255, 8'd128);
        set_req(2, 8'd255, 8'd128);
        serve(4'b0100, 0, got);
        chk("prod_255x128_range", 32'(got >= 8'd127 && got <= 8'd128), 32'd1);

        // A=0 on requester 3 (leaves the pointer at 0).
        push(3, 8'd0, 8'd200);
        set_req(3, 8'd0, 8'd200);
        serve(4'b1000, 0, got);

        // All four requesters held valid: grant order 0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_req(i, 8'(4 + 3*i), 8'(40 + 50*i));
        for (int i = 0; i < 4; i++) push(i, 8'(4 + 3*i), 8'(40 + 50*i));
        push(0, 8'd4, 8'd40);
        for (int i = 0; i < 4; i++) serve(4'b0000, 0, got);
        serve(4'b1111, 0, got);

        // Only requester 3, then only requester 1.
        push(3, 8'd6, 8'd77);
        set_req(3, 8'd6, 8'd77);
        serve(4'b1000, 0, got);
        push(1, 8'd11, 8'd150);
        set_req(1, 8'd11, 8'd150);
        serve(4'b0010, 0, got);

        // Result held 20 cycles while another requester waits.
        set_req(0, 8'd20, 8'd100);
        set_req(3, 8'd9, 8'd33);
        push(3, 8'd9, 8'd33);
        push(0, 8'd20, 8'd100);
        serve(4'b1000, 20, got);
        serve(4'b0001, 0, got);

        // Reset in the middle of a pass aborts the job.
        set_req(2, 8'd100, 8'd50);
        #1;
        n = 0;
        while (req_ready[2] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_grant", 32'(req_ready), 32'd4);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (30) @(negedge clk);
        chk("abort_running", 32'({res_valid, mul_iA}), 32'd100);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_res",       32'({res_valid, res_id, res_data}), 32'd0);
        chk("midrst_mul",       32'({mul_iA, mul_iB, mul_loadA, mul_loadB}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_no_result", 32'(res_valid), 32'd0);
        push(1, 8'd37, 8'd90);
        set_req(1, 8'd37, 8'd90);
        serve(4'b0010, 0, got);

        // Full-scale operands and a zero B.
        push(0, 8'd255, 8'd255);
        set_req(0, 8'd255, 8'd255);
        serve(4'b0001, 0, got);
        chk("prod_255x255_min", 32'(got >= 8'd253), 32'd1);
        push(1, 8'd1, 8'd0);
        set_req(1, 8'd1, 8'd0);
        serve(4'b0010, 0, got);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
